// File: rtl/gain_applier.sv
// gain_applier: scales unsigned amplitude samples by an unsigned Q(QUOTIENT).(FRACTIONAL)
// gain with a serial shift-add multiplier. Results are truncated and saturated.
// Samples move through valid/ready handshakes, one sample in flight at a time.
module gain_applier #(
    parameter int AMPLITUDE_DATA_SIZE = 16,
    parameter int QUOTIENT_SIZE       = 8,
    parameter int FRACTIONAL_SIZE     = 8
) (
    input  logic                           i_clock,
    input  logic                           i_reset_n,
    input  logic [QUOTIENT_SIZE-1:0]       i_quotient,
    input  logic [FRACTIONAL_SIZE-1:0]     i_fractional,
    input  logic                           i_gain_valid,
    input  logic [AMPLITUDE_DATA_SIZE-1:0] i_sample,
    input  logic                           i_sample_valid,
    output logic                           o_sample_ready,
    output logic [AMPLITUDE_DATA_SIZE-1:0] o_sample,
    output logic                           o_sample_valid,
    input  logic                           i_sample_ready,
    output logic                           o_saturated
);

    localparam int GAIN_W = QUOTIENT_SIZE + FRACTIONAL_SIZE;
    localparam int ACC_W  = AMPLITUDE_DATA_SIZE + GAIN_W;
    localparam int CNT_W  = (GAIN_W > 1) ? $clog2(GAIN_W) : 1;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = {{(GAIN_W-1){1'b0}}, 1'b1} << FRACTIONAL_SIZE;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(GAIN_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                         r_state;
    logic [GAIN_W-1:0]              r_gain;
    logic [GAIN_W-1:0]              r_gain_snap;
    logic [AMPLITUDE_DATA_SIZE-1:0] r_samp_snap;
    logic [ACC_W-1:0]               r_acc;
    logic [CNT_W-1:0]               r_cnt;
    logic [AMPLITUDE_DATA_SIZE-1:0] r_out;
    logic                           r_sat;
    logic                           r_ready;
    logic                           r_valid;

    logic [ACC_W-1:0]               w_addend;
    logic [ACC_W-1:0]               w_acc_next;
    logic [ACC_W-1:0]               w_prod;
    logic                           w_ovf;
    logic                           w_last;

    // Gain holding register; any load is accepted regardless of FSM state.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            r_gain <= GAIN_UNITY;
        else if (i_gain_valid)
            r_gain <= {i_quotient, i_fractional};
    end

    // One partial product per cycle plus the truncate/saturate view of the final sum.
    always_comb begin
        w_addend   = '0;
        if (r_gain_snap[r_cnt])
            w_addend = ACC_W'(r_samp_snap) << r_cnt;
        w_acc_next = r_acc + w_addend;
        w_prod     = w_acc_next >> FRACTIONAL_SIZE;
        w_ovf      = |w_prod[ACC_W-1:AMPLITUDE_DATA_SIZE];
        w_last     = (r_cnt == CNT_LAST);
    end

    // Control FSM with registered handshake outputs and result register.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_gain_snap <= '0;
            r_samp_snap <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out       <= '0;
            r_sat       <= 1'b0;
            r_ready     <= 1'b1;
            r_valid     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_sample_valid) begin
                        // Snapshot uses the pre-edge gain, so a same-edge load lands next sample.
                        r_samp_snap <= i_sample;
                        r_gain_snap <= r_gain;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_ready     <= 1'b0;
                        r_state     <= MUL;
                    end
                end
                MUL: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_out   <= w_ovf ? '1 : w_prod[AMPLITUDE_DATA_SIZE-1:0];
                        r_sat   <= w_ovf;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (i_sample_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_sample_ready = r_ready;
    assign o_sample_valid = r_valid;
    assign o_sample       = r_out;
    assign o_saturated    = r_sat;

endmodule
